// File: rtl/key_byte_sequencer.sv
// Key byte selector for the RC4 key-scheduling loop: holds the candidate key,
// supports load/step, and returns key byte [i mod KEY_BYTES] per handshake.
module key_byte_sequencer #(
  parameter int                KEY_BYTES  = 3,
  parameter int                KEY_W      = 8 * KEY_BYTES,
  parameter logic [KEY_W-1:0]  KEY_MAX    = KEY_W'(24'h3FFFFF),
  parameter int                HEX_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7:0]              i_counter,
  input  logic                    load_key,
  input  logic                    key_next,
  input  logic [KEY_W-1:0]        secret_key_input,
  output logic [7:0]              secret_key_value,
  output logic                    finish,
  output logic                    busy,
  output logic                    key_exhausted,
  output logic [KEY_W-1:0]        key_out,
  output logic [4*HEX_DIGITS-1:0] hex_out,
  output logic [2:0]              state
);

  localparam int         HEX_W = 4 * HEX_DIGITS;
  localparam int         EXT_W = (KEY_W > HEX_W) ? KEY_W : HEX_W;
  localparam logic [7:0] KB8   = 8'(KEY_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOD    = 3'd1,
    SELECT = 3'd2,
    HEX    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           st;
  logic [7:0]       rem;
  logic [KEY_W-1:0] key_reg;
  logic [7:0]       sel_byte;
  logic [EXT_W-1:0] key_ext;

  // Byte 0 is the most significant byte of the key.
  always_comb begin
    // NOTE: default first so every path assigns sel_byte and no latch is inferred.
    sel_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (rem == 8'(b)) sel_byte = key_reg[KEY_W-1-8*b -: 8];
  end

  // Zero-extend so display digits above the key width read as 0.
  assign key_ext = EXT_W'(key_reg);

  assign busy    = (st != IDLE);
  assign key_out = key_reg;
  assign state   = st;

  // NOTE: all state uses non-blocking assignments; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st               <= IDLE;
      rem              <= '0;
      key_reg          <= '0;
      key_exhausted    <= 1'b0;
      secret_key_value <= '0;
      hex_out          <= '0;
      finish           <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (st)
        IDLE: begin
          if (load_key) begin
            key_reg       <= secret_key_input;
            key_exhausted <= 1'b0;
          end else if (key_next) begin
            if (key_reg < KEY_MAX) key_reg <= key_reg + KEY_W'(1);
            else                   key_exhausted <= 1'b1;
          end
          if (start) begin
            rem <= i_counter;
            st  <= MOD;
          end
        end
        MOD: begin
          // Modulo by repeated subtraction: one cycle per KEY_BYTES step.
          if (rem >= KB8) rem <= rem - KB8;
          else            st  <= SELECT;
        end
        SELECT: begin
          secret_key_value <= sel_byte;
          st               <= HEX;
        end
        HEX: begin
          hex_out <= key_ext[HEX_W-1:0];
          finish  <= 1'b1;
          st      <= DONE;
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_byte_sequencer.sv
// Scoreboard bench for key_byte_sequencer: a driver pushes expected lookups
// from a key model, a monitor pops and compares on every finish pulse.
module tb_key_byte_sequencer;

  localparam int          KB   = 3;
  localparam logic [23:0] KMAX = 24'h3FFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, load_key = 1'b0, key_next = 1'b0;
  logic [7:0]  i_counter = '0;
  logic [23:0] secret_key_input = '0;
  logic [7:0]  secret_key_value;
  logic        finish, busy, key_exhausted;
  logic [23:0] key_out, hex_out;
  logic [2:0]  state;

  // Second instance for the 4-byte key variant.
  logic        start4 = 1'b0, load4 = 1'b0, next4 = 1'b0;
  logic [7:0]  i4 = '0;
  logic [31:0] key_in4 = '0;
  logic [7:0]  skv4;
  logic        fin4, busy4, exh4;
  logic [31:0] key_out4;
  logic [23:0] hex4;
  logic [2:0]  state4;

  key_byte_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .i_counter(i_counter),
    .load_key(load_key), .key_next(key_next), .secret_key_input(secret_key_input),
    .secret_key_value(secret_key_value), .finish(finish), .busy(busy),
    .key_exhausted(key_exhausted), .key_out(key_out), .hex_out(hex_out), .state(state)
  );

  key_byte_sequencer #(.KEY_BYTES(4), .KEY_MAX(32'hFFFFFFFF), .HEX_DIGITS(6)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .i_counter(i4),
    .load_key(load4), .key_next(next4), .secret_key_input(key_in4),
    .secret_key_value(skv4), .finish(fin4), .busy(busy4),
    .key_exhausted(exh4), .key_out(key_out4), .hex_out(hex4), .state(state4)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  kbyte;
    logic [23:0] hex;
    longint      edge_n;
  } exp_t;
  exp_t sb[$];

  // Reference key state.
  logic [23:0] mkey = '0;
  logic        mexh = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every finish pulse must match the oldest outstanding lookup.
  always @(negedge clk) begin
    if (reset_n && finish) begin
      if (sb.size() == 0) check("unexpected_finish", 64'(finish), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("key_byte", 64'(secret_key_value), 64'(e.kbyte));
        check("hex_out", 64'(hex_out), 64'(e.hex));
        check("finish_edge", 64'(cyc), 64'(e.edge_n));
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Called at a negedge with the DUT idle; applies one IDLE cycle of controls.
  task automatic idle_op(logic st, logic ld, logic nx, logic [7:0] i, logic [23:0] k, logic poke);
    exp_t e;
    start = st; load_key = ld; key_next = nx; i_counter = i; secret_key_input = k;
    if (ld) begin mkey = k; mexh = 1'b0; end
    else if (nx) begin
      if (mkey < KMAX) mkey = mkey + 24'd1;
      else             mexh = 1'b1;
    end
    if (st) begin
      e.kbyte  = 8'(mkey >> (8 * (KB - 1 - (int'(i) % KB))));
      e.hex    = mkey;
      e.edge_n = cyc + 1 + longint'(int'(i) / KB) + 3;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; load_key = 1'b0; key_next = 1'b0;
    if (st) begin
      check("busy_in_lookup", 64'(busy), 64'd1);
      if (poke) begin
        start = 1'b1; load_key = 1'b1; key_next = 1'b1;
        i_counter = 8'($urandom); secret_key_input = 24'($urandom);
        @(negedge clk);
        start = 1'b0; load_key = 1'b0; key_next = 1'b0;
      end
    end
    wait_idle();
    check("key_out", 64'(key_out), 64'(mkey));
    check("key_exhausted", 64'(key_exhausted), 64'(mexh));
  endtask

  task automatic do_reset(int n);
    reset_n = 1'b0;
    start = 1'($urandom); load_key = 1'($urandom); key_next = 1'($urandom);
    i_counter = 8'($urandom); secret_key_input = 24'($urandom);
    repeat (n) @(negedge clk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_value", 64'(secret_key_value), 64'd0);
    check("rst_key", 64'(key_out), 64'd0);
    check("rst_hex", 64'(hex_out), 64'd0);
    check("rst_exh", 64'(key_exhausted), 64'd0);
    sb.delete();
    mkey = '0; mexh = 1'b0;
    start = 1'b0; load_key = 1'b0; key_next = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    longint e0;
    bit     seen;
    @(negedge clk);
    do_reset(2);

    // 4-byte variant: byte 7 mod 4 = 3 is the LSB; only 6 nibbles shown.
    load4 = 1'b1; key_in4 = 32'h01234567;
    @(negedge clk);
    load4 = 1'b0; start4 = 1'b1; i4 = 8'd7; e0 = cyc + 1;
    @(negedge clk);
    start4 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (fin4) begin
        seen = 1'b1;
        check("v4_byte", 64'(skv4), 64'h67);
        check("v4_hex", 64'(hex4), 64'h234567);
        check("v4_edge", 64'(cyc), 64'(e0 + 4));
      end else @(negedge clk);
    end
    if (!seen) check("v4_timeout", 64'(fin4), 64'd1);
    while (busy4) @(negedge clk);

    // Load and index sweep.
    idle_op(0, 1, 0, 8'd0, 24'h490326, 0);
    idle_op(1, 0, 0, 8'd0, 24'h0, 0);
    idle_op(1, 0, 0, 8'd4, 24'h0, 0);
    idle_op(1, 0, 0, 8'd5, 24'h0, 0);
    idle_op(1, 0, 0, 8'd255, 24'h0, 0);

    // Stepping up to and past KEY_MAX.
    idle_op(0, 1, 0, 8'd0, 24'h3FFFFE, 0);
    idle_op(0, 0, 1, 8'd0, 24'h0, 0);
    idle_op(0, 0, 1, 8'd0, 24'h0, 0);
    check("step_to_max", 64'(key_out), 64'h3FFFFF);
    check("exhausted_set", 64'(key_exhausted), 64'd1);
    idle_op(0, 0, 1, 8'd0, 24'h0, 0);
    check("step_hold", 64'(key_out), 64'h3FFFFF);
    idle_op(0, 1, 0, 8'd0, 24'h123456, 0);
    check("exhausted_clear", 64'(key_exhausted), 64'd0);

    // Inputs while busy are ignored; same-cycle load + start uses new key.
    idle_op(1, 0, 0, 8'd10, 24'h0, 1);
    idle_op(1, 1, 0, 8'd2, 24'hAABBCC, 0);

    // Reset during MOD aborts the lookup with no finish pulse.
    start = 1'b1; i_counter = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    mkey = '0; mexh = 1'b0;
    @(negedge clk);
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_finish", 64'(finish), 64'd0);
    check("midrst_key", 64'(key_out), 64'd0);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int          r;
      logic [23:0] k;
      r = int'($urandom_range(0, 9));
      k = (r < 1) ? KMAX - 24'($urandom_range(0, 2)) : 24'($urandom);
      idle_op(1'($urandom_range(0, 3) != 0), r < 2, r >= 2 && r <= 5,
              8'($urandom_range(0, 40)), k, 1'($urandom));
    end

    do_reset(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_byte_sequencer.md
Name: key_byte_sequencer

Overview:
- Parametrised successor to the fixed 3-byte secret-key selector in the RC4 decryption datapath.
- Holds the current candidate key in an internal register. The key can be loaded, or stepped by one for brute-force search.
- For each handshake it returns key byte [i mod KEY_BYTES] to the key-scheduling loop and refreshes the hex display.
- The modulo is done by sequential subtraction, so there is no divider.

Parameters:
- KEY_BYTES, 3, key length in bytes; legal range 1..16.
- KEY_W, 8*KEY_BYTES, key register width (derived; not overridden).
- KEY_MAX, 24'h3FFFFF, highest key value reachable by stepping; width KEY_W.
- HEX_DIGITS, 6, number of 4-bit display digits driven.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset_n, input, 1, synchronous active-low reset.
- start, input, 1, request one byte lookup; sampled only in IDLE.
- i_counter, input, 8, KSA index; captured when start is accepted.
- load_key, input, 1, in IDLE: key_reg <= secret_key_input.
- key_next, input, 1, in IDLE: step key_reg by +1.
- secret_key_input, input, KEY_W, key value to load.
- secret_key_value, output, 8, selected key byte; registered.
- finish, output, 1, one-cycle done pulse.
- busy, output, 1, high whenever state != IDLE.
- key_exhausted, output, 1, sticky; set on a key_next attempt at KEY_MAX.
- key_out, output, KEY_W, current key_reg.
- hex_out, output, 4*HEX_DIGITS, display nibbles; digit d = hex_out[4d+3:4d].
- state, output, 3, FSM state, for debug.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE. secret_key_value, finish, key_exhausted, key_reg, hex_out and the internal remainder all go to 0. Reset overrides everything, including mid-operation.
- State encodings: IDLE=0, MOD=1, SELECT=2, HEX=3, DONE=4. Other codes go to IDLE on the next edge.
- IDLE:
  - load_key=1: key_reg <= secret_key_input and key_exhausted <= 0.
  - Else if key_next=1: if key_reg < KEY_MAX then key_reg+1, else key_reg holds and key_exhausted <= 1. No wrap.
  - start=1: rem <= i_counter, go to MOD. start is independent of load_key/key_next; a same-cycle load/step is applied and the lookup uses the updated key.
- MOD:
  - If rem >= KEY_BYTES: rem <= rem - KEY_BYTES and stay.
  - Else go to SELECT.
  - Cycles spent in MOD = floor(i/KEY_BYTES)+1.
- SELECT: secret_key_value <= key_reg[KEY_W-1-8*rem -: 8]. Byte 0 is the most significant byte. Go to HEX.
- HEX:
  - hex_out digit d <= key_reg[4d+3:4d] for 4d < KEY_W.
  - Digits with 4d >= KEY_W <= 0; key nibbles beyond HEX_DIGITS are not shown.
  - Go to DONE.
- DONE: finish=1 for exactly this one cycle (registered, set on the edge entering DONE). Next edge: IDLE with finish=0.
- Latency: start accepted at edge E0 → finish high after edge E0+floor(i/KEY_BYTES)+3.
- While busy:
  - start, load_key and key_next are ignored, not queued.
  - i_counter and secret_key_input changes have no effect.
- secret_key_value and hex_out hold their values until the next SELECT/HEX or reset.
- start held high continuously: a new lookup begins on the edge after DONE returns to IDLE.
- key_exhausted clears only on reset or load_key.

Test Plan:
- Reset: reset_n=0 for 2 cycles with random inputs → all outputs 0, state=0, busy=0.
- Load and lookup, i=0: load key 24'h490326, then start with i=0 → finish after E0+3, secret_key_value=8'h49, hex_out=24'h490326.
- Index sweep: i=4 → 8'h03, finish at E0+4; i=5 → 8'h26; i=255 → 8'h49, finish at E0+88; busy high throughout each lookup.
- Key stepping: load 24'h3FFFFE, key_next twice → key_out=24'h3FFFFF, key_exhausted=1. A third key_next → unchanged. load_key → key_exhausted=0.
- Handshake edges:
  - start pulse while busy → ignored; exactly one finish pulse.
  - start+load_key in the same IDLE cycle (load 24'hAABBCC, i=2) → 8'hCC.
  - reset_n=0 during MOD with i=200 → IDLE next edge, no finish pulse.
- Parameter variant, KEY_BYTES=4, KEY_MAX=32'hFFFFFFFF: load 32'h01234567, i=7 → 8'h67 with finish at E0+4. hex_out=24'h234567, showing only the low 6 nibbles.
